// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures control bundle and operands, detects load-use hazards
// against EX and stalls PC/IF-ID for one cycle while inserting a bubble; EX flushes also bubble.
// Latency 1 cycle; o_stall is combinational from EX state and ID inputs.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_pc_sel,
    input  logic             i_rd_wren,
    input  logic             i_br_un,
    input  logic             i_opa_sel,
    input  logic             i_opb_sel,
    input  logic             i_mem_wren,
    input  logic [3:0]       i_alu_op,
    input  logic [1:0]       i_wb_sel,
    input  logic [3:0]       i_lsu_op,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic [XLEN-1:0]  o_imm,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic             o_pc_sel,
    output logic             o_rd_wren,
    output logic             o_br_un,
    output logic             o_opa_sel,
    output logic             o_opb_sel,
    output logic             o_mem_wren,
    output logic [3:0]       o_alu_op,
    output logic [1:0]       o_wb_sel,
    output logic [3:0]       o_lsu_op,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [1:0] WB_LSU    = 2'b01;
    localparam logic [3:0] LSU_RST   = 4'b0100;

    logic [4:0] opcode, id_rs1, id_rs2, id_rd;
    logic       uses_rs1, uses_rs2, hazard;
    logic       unused_instr_bits;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic             pc_sel_q, pc_sel_d, rd_wren_q, rd_wren_d, br_un_q, br_un_d;
    logic             opa_sel_q, opa_sel_d, opb_sel_q, opb_sel_d, mem_wren_q, mem_wren_d;
    logic [3:0]       alu_op_q, alu_op_d, lsu_op_q, lsu_op_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign opcode            = i_instr[6:2];
    assign id_rs1            = i_instr[19:15];
    assign id_rs2            = i_instr[24:20];
    assign id_rd             = i_instr[11:7];
    assign unused_instr_bits = ^{i_instr[31:25], i_instr[14:12], i_instr[1:0]};

    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // Only a load sitting in EX can produce a use-too-early dependency.
    assign hazard = i_valid && valid_q && rd_wren_q && (wb_sel_q == WB_LSU) && (rd_q != 5'd0) &&
                    ((uses_rs1 && (rd_q == id_rs1)) || (uses_rs2 && (rd_q == id_rs2)));
    assign o_stall = hazard && !i_flush;

    always_comb begin
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        valid_d    = 1'b0;
        rd_d       = 5'd0;
        rs1_d      = 5'd0;
        rs2_d      = 5'd0;
        pc_sel_d   = 1'b0;
        rd_wren_d  = 1'b0;
        br_un_d    = 1'b0;
        opa_sel_d  = 1'b0;
        opb_sel_d  = 1'b1;
        mem_wren_d = 1'b0;
        alu_op_d   = 4'b0000;
        wb_sel_d   = 2'b00;
        lsu_op_d   = LSU_RST;
        if (!i_flush && !hazard && i_valid) begin
            pc_d       = i_pc;
            rs1_data_d = i_rs1_data;
            rs2_data_d = i_rs2_data;
            imm_d      = i_imm;
            valid_d    = 1'b1;
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            pc_sel_d   = i_pc_sel;
            rd_wren_d  = i_rd_wren;
            br_un_d    = i_br_un;
            opa_sel_d  = i_opa_sel;
            opb_sel_d  = i_opb_sel;
            mem_wren_d = i_mem_wren;
            alu_op_d   = i_alu_op;
            wb_sel_d   = i_wb_sel;
            lsu_op_d   = i_lsu_op;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            pc_sel_q    <= 1'b0;
            rd_wren_q   <= 1'b0;
            br_un_q     <= 1'b0;
            opa_sel_q   <= 1'b0;
            opb_sel_q   <= 1'b1;
            mem_wren_q  <= 1'b0;
            alu_op_q    <= 4'b0000;
            wb_sel_q    <= 2'b00;
            lsu_op_q    <= LSU_RST;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            pc_sel_q    <= pc_sel_d;
            rd_wren_q   <= rd_wren_d;
            br_un_q     <= br_un_d;
            opa_sel_q   <= opa_sel_d;
            opb_sel_q   <= opb_sel_d;
            mem_wren_q  <= mem_wren_d;
            alu_op_q    <= alu_op_d;
            wb_sel_q    <= wb_sel_d;
            lsu_op_q    <= lsu_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_rs1_data  = rs1_data_q;
    assign o_rs2_data  = rs2_data_q;
    assign o_imm       = imm_q;
    assign o_rd        = rd_q;
    assign o_rs1       = rs1_q;
    assign o_rs2       = rs2_q;
    assign o_pc_sel    = pc_sel_q;
    assign o_rd_wren   = rd_wren_q;
    assign o_br_un     = br_un_q;
    assign o_opa_sel   = opa_sel_q;
    assign o_opb_sel   = opb_sel_q;
    assign o_mem_wren  = mem_wren_q;
    assign o_alu_op    = alu_op_q;
    assign o_wb_sel    = wb_sel_q;
    assign o_lsu_op    = lsu_op_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stalls, false-stall cases,
// flush priority, counter saturation (small CNT_W) and asynchronous reset mid-stall.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [31:0] ADD_X3  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] LW_X5   = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] ADD_X6  = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD_X0  = 32'h00700333; // add x6,x0,x7
    localparam logic [31:0] LUI_X8  = 32'h00028437; // lui x8 with rs1 field = 5
    localparam logic [31:0] SW_X5   = 32'h00512223; // sw  x5,4(x2)

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic [31:0]      i_instr;
    logic [XLEN-1:0]  i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic             i_pc_sel, i_rd_wren, i_br_un, i_opa_sel, i_opb_sel, i_mem_wren;
    logic [3:0]       i_alu_op, i_lsu_op;
    logic [1:0]       i_wb_sel;
    logic             i_flush;
    logic             o_stall, o_valid;
    logic [XLEN-1:0]  o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]       o_rd, o_rs1, o_rs2;
    logic             o_pc_sel, o_rd_wren, o_br_un, o_opa_sel, o_opb_sel, o_mem_wren;
    logic [3:0]       o_alu_op, o_lsu_op;
    logic [1:0]       o_wb_sel;
    logic [CNT_W-1:0] o_stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_pc_sel(i_pc_sel), .i_rd_wren(i_rd_wren), .i_br_un(i_br_un), .i_opa_sel(i_opa_sel),
        .i_opb_sel(i_opb_sel), .i_mem_wren(i_mem_wren), .i_alu_op(i_alu_op),
        .i_wb_sel(i_wb_sel), .i_lsu_op(i_lsu_op), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_pc_sel(o_pc_sel), .o_rd_wren(o_rd_wren), .o_br_un(o_br_un), .o_opa_sel(o_opa_sel),
        .o_opb_sel(o_opb_sel), .o_mem_wren(o_mem_wren), .o_alu_op(o_alu_op),
        .o_wb_sel(o_wb_sel), .o_lsu_op(o_lsu_op), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one ID instruction with its control bundle; operand data derived from PC.
    task automatic set_id(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic rd_wren, input logic mem_wren, input logic [1:0] wb_sel,
                          input logic [3:0] alu_op, input logic [3:0] lsu_op, input logic opb_sel);
        i_valid    = v;
        i_instr    = instr;
        i_pc       = pc;
        i_rs1_data = pc + 32'h1000;
        i_rs2_data = pc + 32'h2000;
        i_imm      = pc + 32'h3000;
        i_rd_wren  = rd_wren;
        i_mem_wren = mem_wren;
        i_wb_sel   = wb_sel;
        i_alu_op   = alu_op;
        i_lsu_op   = lsu_op;
        i_opb_sel  = opb_sel;
        i_pc_sel   = 1'b0;
        i_br_un    = 1'b0;
        i_opa_sel  = 1'b0;
        #1;
    endtask

    task automatic set_lw_x5(input logic [31:0] pc);
        set_id(1'b1, LW_X5, pc, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0010, 1'b1);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_flush = 1'b0;
        set_id(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);

        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_stall", o_stall, 1'b0);
        end
        i_rst = 1'b0;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_opb_sel", o_opb_sel, 1'b1);
        chk("rst_lsu_op", o_lsu_op, 4'b0100);
        chk("rst_ctrl", {o_pc_sel, o_rd_wren, o_br_un, o_opa_sel, o_mem_wren, o_alu_op, o_wb_sel}, 11'd0);
        chk("rst_regidx", {o_rd, o_rs1, o_rs2}, 15'd0);
        chk("rst_data", {o_pc, o_rs1_data, o_rs2_data, o_imm} == '0, 1'b1);
        chk("rst_cnt", o_stall_cnt, 4'd0);

        // Pass-through: add x3,x1,x2 at PC 0x100.
        set_id(1'b1, ADD_X3, 32'h100, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        chk("pt_stall", o_stall, 1'b0);
        tick();
        chk("pt_valid", o_valid, 1'b1);
        chk("pt_rd", o_rd, 5'd3);
        chk("pt_rs", {o_rs1, o_rs2}, {5'd1, 5'd2});
        chk("pt_alu", o_alu_op, 4'b0000);
        chk("pt_pc", o_pc, 32'h100);
        chk("pt_data", {o_rs1_data, o_rs2_data, o_imm}, {32'h1100, 32'h2100, 32'h3100});

        // Load-use on rs1.
        set_lw_x5(32'h104);
        chk("lu_lw_nostall", o_stall, 1'b0);
        tick();
        chk("lu_lw_in_ex", {o_valid, o_wb_sel, o_lsu_op, o_rd}, {1'b1, 2'b01, 4'b0010, 5'd5});
        set_id(1'b1, ADD_X6, 32'h108, 1'b1, 1'b0, 2'b00, 4'b0011, 4'b0000, 1'b0);
        chk("lu_stall", o_stall, 1'b1);
        tick();
        chk("lu_bubble_valid", o_valid, 1'b0);
        chk("lu_bubble_wren", o_rd_wren, 1'b0);
        chk("lu_bubble_ctrl", {o_rd, o_opb_sel, o_lsu_op, o_wb_sel}, {5'd0, 1'b1, 4'b0100, 2'b00});
        chk("lu_cnt1", o_stall_cnt, 4'd1);
        chk("lu_stall_clear", o_stall, 1'b0);
        tick();
        chk("lu_add_adv", {o_valid, o_rd, o_pc, o_alu_op}, {1'b1, 5'd6, 32'h108, 4'b0011});
        chk("lu_cnt_hold", o_stall_cnt, 4'd1);

        // lw x0 then use of x0: no stall.
        set_id(1'b1, LW_X0, 32'h10C, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0010, 1'b1);
        tick();
        set_id(1'b1, ADD_X0, 32'h110, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        chk("x0_nostall", o_stall, 1'b0);
        tick();
        chk("x0_adv", {o_valid, o_rd}, {1'b1, 5'd6});

        // lw x5 then lui whose rs1 field is 5: no stall.
        set_lw_x5(32'h114);
        tick();
        set_id(1'b1, LUI_X8, 32'h118, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
        chk("lui_nostall", o_stall, 1'b0);
        tick();
        chk("lui_adv", {o_valid, o_rd, o_pc}, {1'b1, 5'd8, 32'h118});
        chk("lui_cnt", o_stall_cnt, 4'd1);

        // Store data dependency through rs2.
        set_lw_x5(32'h11C);
        tick();
        set_id(1'b1, SW_X5, 32'h120, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b1010, 1'b1);
        chk("sw_stall", o_stall, 1'b1);
        tick();
        chk("sw_bubble", {o_valid, o_mem_wren}, 2'b00);
        chk("sw_stall_clear", o_stall, 1'b0);
        tick();
        chk("sw_adv", {o_valid, o_mem_wren, o_rs1, o_rs2, o_rd}, {1'b1, 1'b1, 5'd2, 5'd5, 5'd4});
        chk("sw_cnt", o_stall_cnt, 4'd2);

        // Flush coincident with a hazard.
        set_lw_x5(32'h124);
        tick();
        set_id(1'b1, ADD_X6, 32'h128, 1'b1, 1'b0, 2'b00, 4'b0011, 4'b0000, 1'b0);
        i_flush = 1'b1;
        #1;
        chk("fl_nostall", o_stall, 1'b0);
        tick();
        chk("fl_bubble", {o_valid, o_rd, o_rd_wren}, {1'b0, 5'd0, 1'b0});
        chk("fl_cnt", o_stall_cnt, 4'd2);
        i_flush = 1'b0;

        // Invalid ID instruction loads a bubble.
        set_id(1'b0, ADD_X3, 32'h12C, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        tick();
        chk("inv_bubble", {o_valid, o_rd_wren, o_rd}, {1'b0, 1'b0, 5'd0});

        // 2^CNT_W+2 further stalls: counter must saturate at all-ones.
        for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
            set_lw_x5(32'h200);
            tick();
            set_id(1'b1, ADD_X6, 32'h204, 1'b1, 1'b0, 2'b00, 4'b0011, 4'b0000, 1'b0);
            tick();
        end
        chk("sat_cnt", o_stall_cnt, 4'hF);

        // Asynchronous reset in the middle of a stall.
        set_lw_x5(32'h300);
        tick();
        set_id(1'b1, ADD_X6, 32'h304, 1'b1, 1'b0, 2'b00, 4'b0011, 4'b0000, 1'b0);
        chk("ar_stall_pre", o_stall, 1'b1);
        i_rst = 1'b1;
        #1;
        chk("ar_stall", o_stall, 1'b0);
        chk("ar_state", {o_valid, o_rd, o_stall_cnt, o_lsu_op}, {1'b0, 5'd0, 4'd0, 4'b0100});
        tick();
        i_rst = 1'b0;
        #1;
        tick();
        chk("ar_resume", {o_valid, o_rd}, {1'b1, 5'd6});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
